mux8_arbiter: RTL and testbench
===============================

MUX8_ARBITER -- requirements
Module: mux8_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum number of consecutive cycles one requester SHALL hold the grant (legal range 2..255).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request per requester; req[i] owns mux data input d<i>.
REQ-005 done  input  1  release strobe from the current owner, valid only while busy=1.
REQ-006 gnt  output  8  one-hot grant, registered; all zero when no owner.
REQ-007 s  output  3  mux8_1 select, registered; SHALL equal the index of the set gnt bit whenever busy=1.
REQ-008 busy  output  1  high while a requester owns the mux.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 Internal state SHALL comprise: round-robin pointer ptr (3 bits); hold counter cnt (8 bits); FSM state.
REQ-012 IDLE, req==0: SHALL remain in IDLE; gnt=0, busy=0; s holds its last value.
REQ-013 IDLE, req!=0: winner SHALL be the first set req bit searching ptr, ptr+1, ..., ptr+7 (mod 8).
REQ-014 On the edge that samples a nonzero req in IDLE, the block SHALL enter GRANT and set gnt[w]=1, s=w, busy=1, cnt=0 (latency: one cycle from req to gnt).
REQ-015 GRANT: each cycle without release, cnt SHALL increment by 1.
REQ-016 GRANT release conditions, evaluated every cycle: done==1, or req[s]==0, or cnt==MAX_HOLD-1.
REQ-017 On release, the block SHALL return to IDLE on the next edge, clear gnt and busy, and set ptr=(s+1) mod 8 (wrap 7->0).
REQ-018 timeout SHALL pulse high for exactly the cycle following a release caused solely by cnt==MAX_HOLD-1 (done==0 and req[s]==1).
REQ-019 If done and the hold limit coincide, done SHALL take priority and timeout SHALL stay 0.
REQ-020 After every release, at least one IDLE cycle SHALL occur; back-to-back grants without a gap are not permitted.
REQ-021 Changes to req bits other than req[s] during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-022 done asserted in IDLE SHALL be ignored.
REQ-023 gnt SHALL never have more than one bit set; gnt, s and busy SHALL be mutually consistent on every cycle.

Reset
REQ-024 rst=1 at a rising edge SHALL force: state=IDLE, gnt=0, s=0, busy=0, timeout=0, ptr=0, cnt=0.
REQ-025 Reset asserted during GRANT SHALL drop the grant on that same edge, with no timeout pulse.
REQ-026 rst SHALL take priority over all other inputs; outputs SHALL be undefined only before the first reset edge.

Verification
REQ-027 Reset then req=8'b0000_0000 for 5 cycles -> gnt=0, s=0, busy=0, timeout=0 throughout.
REQ-028 ptr=0, req=8'b1000_0100 -> next cycle gnt=8'b0000_0100, s=2; done pulse -> IDLE; then with req unchanged, next grant is gnt=8'b1000_0000, s=7; after its release, ptr=0 (wrap-around).
REQ-029 MAX_HOLD=16, req=8'b0000_0001 held high, done=0 -> gnt held exactly 16 cycles, timeout=1 for one cycle, one IDLE cycle, then re-grant to requester 0.
REQ-030 Owner deasserts req[s] mid-grant (cycle 3) -> release with timeout=0; ptr advances to s+1.
REQ-031 Apply rst=1 during GRANT with s=5 -> next cycle gnt=0, s=0, busy=0; with req=8'b0010_0001, the following grant goes to requester 0 (ptr reset).
REQ-032 Co-simulate with mux8_1 driven by s and random d0..d7 -> mux y equals d<s> on every busy cycle; gnt one-hot checked every cycle.

Source files
------------

// File: rtl/mux8_arbiter_if.sv
// Request/grant bundle between the requesters and the mux8 arbiter.
interface mux8_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       timeout;

    modport master (
        output req, done,
        input  gnt, s, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, s, busy, timeout
    );
endinterface

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 mux. A winner holds the
// mux until it strobes done, drops its request, or hits the hold limit.
module mux8_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic            clk,
    input logic            rst,
    mux8_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] gnt_q, gnt_nxt;
    logic [2:0] s_q, s_nxt;
    logic       busy_q, busy_nxt;
    logic       to_q, to_nxt;

    logic       found;
    logic [2:0] win;
    logic [2:0] idx;
    logic       release_now;

    // Rotating-priority search: first set request starting at ptr.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        gnt_nxt     = gnt_q;
        s_nxt       = s_q;
        busy_nxt    = busy_q;
        to_nxt      = 1'b0;
        release_now = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 8'b1 << win;
                    s_nxt     = win;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                release_now = bus.done || !bus.req[s_q] || (cnt == HOLD_LAST);
                if (release_now) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = s_q + 3'd1;
                    // Only the hold limit is left as a cause when done is low
                    // and the owner still requests.
                    to_nxt    = !bus.done && bus.req[s_q];
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            gnt_q  <= '0;
            s_q    <= '0;
            busy_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            cnt    <= cnt_nxt;
            gnt_q  <= gnt_nxt;
            s_q    <= s_nxt;
            busy_q <= busy_nxt;
            to_q   <= to_nxt;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.s       = s_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = to_q;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Bench for mux8_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against an owner/held-cycles model and a mux8_1 check.
module tb_mux8_arbiter;

    localparam int MH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mux8_arbiter_if bus ();

    mux8_arbiter #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: which requester owns the mux (-1 = none) and for how many cycles.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_ptr   = 0;
    int   m_s     = 0;
    bit   m_to    = 1'b0;
    bit   m_valid = 1'b0;

    logic [7:0] d_arr [8];

    function automatic logic [7:0] mux8_1(input logic [2:0] sel, input logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7);
        case (sel)
            3'd0: return d0;
            3'd1: return d1;
            3'd2: return d2;
            3'd3: return d3;
            3'd4: return d4;
            3'd5: return d5;
            3'd6: return d6;
            default: return d7;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model update from the inputs seen at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_s = 0; m_to = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < 8; k++) begin
                    int j;
                    j = (m_ptr + k) % 8;
                    if (m_owner < 0 && bus.req[j]) begin
                        m_owner = j; m_s = j; m_held = 1;
                    end
                end
            end else if (bus.done || !bus.req[m_owner] || m_held == MH) begin
                m_to    = !bus.done && bus.req[m_owner];
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [7:0] y;
            for (int i = 0; i < 8; i++) d_arr[i] = 8'($urandom);
            chk("gnt", bus.gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("s", bus.s, m_s);
            chk("busy", bus.busy, (m_owner >= 0) ? 1 : 0);
            chk("timeout", bus.timeout, m_to);
            chk("gnt_onehot0", $onehot0(bus.gnt), 1);
            if (bus.busy) begin
                chk("gnt_vs_s", bus.gnt, 32'd1 << bus.s);
                y = mux8_1(bus.s, d_arr[0], d_arr[1], d_arr[2], d_arr[3],
                           d_arr[4], d_arr[5], d_arr[6], d_arr[7]);
                chk("mux_y", y, d_arr[m_s]);
            end
        end
    end

    initial begin
        int n;
        bus.req  = '0;
        bus.done = 1'b0;

        // Reset then idle requests
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_s", bus.s, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_timeout", bus.timeout, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_gnt", bus.gnt, 0);
            chk("idle_busy", bus.busy, 0);
        end

        // Round-robin with wrap
        bus.req = 8'b1000_0100;
        step();
        chk("rr_gnt2", bus.gnt, 8'b0000_0100);
        chk("rr_s2", bus.s, 2);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("rr_rel_busy", bus.busy, 0);
        chk("rr_rel_s_hold", bus.s, 2);
        step();
        chk("rr_gnt7", bus.gnt, 8'b1000_0000);
        chk("rr_s7", bus.s, 7);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("rr_rel7_busy", bus.busy, 0);
        bus.req = 8'b0000_0101;
        step();
        chk("rr_wrap_gnt0", bus.gnt, 8'b0000_0001);
        bus.req = '0;
        step();
        chk("req_drop_busy", bus.busy, 0);
        chk("req_drop_timeout", bus.timeout, 0);

        // Hold limit
        bus.req = 8'b0000_0001;
        step();
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            step();
        end
        chk("hold_len", n, MH);
        chk("hold_timeout", bus.timeout, 1);
        chk("hold_gap_busy", bus.busy, 0);
        step();
        chk("hold_regrant", bus.gnt, 8'b0000_0001);
        chk("hold_timeout_clr", bus.timeout, 0);
        bus.req = '0;
        step();
        chk("rel_busy", bus.busy, 0);

        // Owner drops request at cycle 3
        bus.req = 8'b0000_1000;
        step();
        chk("own_gnt3", bus.gnt, 8'b0000_1000);
        step(); step();
        bus.req = 8'b0001_0001;
        step();
        chk("own_rel_busy", bus.busy, 0);
        chk("own_rel_timeout", bus.timeout, 0);
        step();
        chk("own_ptr_adv", bus.gnt, 8'b0001_0000);

        // Reset during grant with s=5
        bus.req = '0;
        step();
        bus.req = 8'b0010_0001;
        step();
        chk("pre_rst_s5", bus.s, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("grst_gnt", bus.gnt, 0);
        chk("grst_s", bus.s, 0);
        chk("grst_busy", bus.busy, 0);
        chk("grst_timeout", bus.timeout, 0);
        step();
        chk("grst_regrant0", bus.gnt, 8'b0000_0001);

        // done coinciding with hold limit: no timeout
        repeat (MH - 1) step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("coinc_busy", bus.busy, 0);
        chk("coinc_timeout", bus.timeout, 0);

        // done in IDLE is ignored
        bus.req  = '0;
        bus.done = 1'b1;
        step();
        bus.req = 8'b0000_0010;
        step();
        chk("done_idle_gnt", bus.gnt, 8'b0000_0010);
        bus.done = 1'b0;
        bus.req  = '0;
        step();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            bus.done = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
